// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment table, decode helper and digit filter state type
package seg_pkg;

  // Active-low segment patterns {a,b,c,d,e,f,g} for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // All segments off (lines are active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HELD
  } dig_state_t;

  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] nibble;
  } seg_dec_t;

  // Reverse lookup of a segment pattern; nibble is 0 unless the pattern is a hex glyph.
  function automatic seg_dec_t seg_decode(input logic [6:0] pat);
    seg_dec_t r;
    r = '0;
    if (pat == SEG_BLANK) begin
      r.blank = 1'b1;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (pat == HEX_SEG[k]) begin
          r.hit    = 1'b1;
          r.nibble = 4'(k);
        end
      end
    end
    return r;
  endfunction

  // Number of low bits in an active-low select word.
  function automatic logic [3:0] low_count(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, ~v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/seg_stable_filter.sv
// rtl/seg_stable_filter.sv - waits for the scanned select/segment pair to settle and strobes it once
module seg_stable_filter
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] an_n,
  input  logic [7:0] seg_in,
  output logic       commit,
  output logic [7:0] st_an,
  output logic [7:0] st_seg
);

  localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

  dig_state_t state, state_nx;
  logic [7:0] s_an, s_seg;
  logic [7:0] cnt, cnt_nx;
  logic       commit_nx;
  logic       chg;

  // The counter holds how many consecutive identical samples sit in s_an/s_seg;
  // reaching the limit evaluates the pair once and parks in HELD until it changes.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    commit_nx = 1'b0;
    chg       = (an_n != s_an) || (seg_in != s_seg);
    case (state)
      IDLE, HELD: begin
        if (chg) begin
          cnt_nx   = 8'd1;
          state_nx = COUNT;
        end
      end
      COUNT: begin
        if (chg) cnt_nx = 8'd1;
        else     cnt_nx = cnt + 8'd1;
      end
      default: state_nx = IDLE;
    endcase
    if ((state_nx == COUNT) && (cnt_nx == STABLE_LIM)) begin
      commit_nx = 1'b1;
      state_nx  = HELD;
    end
  end

  // Sample registers, counter, state and the registered commit strobe with its pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_an   <= 8'hFF;
      s_seg  <= 8'hFF;
      state  <= IDLE;
      cnt    <= 8'd0;
      commit <= 1'b0;
      st_an  <= 8'hFF;
      st_seg <= 8'hFF;
    end else begin
      s_an   <= an_n;
      s_seg  <= seg_in;
      state  <= state_nx;
      cnt    <= cnt_nx;
      commit <= commit_nx;
      if (commit_nx) begin
        st_an  <= an_n;
        st_seg <= seg_in;
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - decodes a scanned 8-digit seven-segment bus into handshaked frames
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NDIG          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an_n,
  input  logic [7:0]  seg_in,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [31:0] digits,
  output logic [7:0]  dp,
  output logic [7:0]  blank,
  output logic [7:0]  bad,
  output logic        sel_err,
  output logic        overrun
);

  logic       commit;
  logic [7:0] st_an, st_seg;

  seg_stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .clk    (clk),
    .rst    (rst),
    .an_n   (an_n),
    .seg_in (seg_in),
    .commit (commit),
    .st_an  (st_an),
    .st_seg (st_seg)
  );

  logic [31:0] w_digits, w_digits_nx;
  logic [7:0]  w_dp, w_dp_nx;
  logic [7:0]  w_blank, w_blank_nx;
  logic [7:0]  w_bad, w_bad_nx;
  logic [7:0]  seen, seen_nx;
  seg_dec_t    dec;
  logic [3:0]  nlow;
  logic [2:0]  idx;
  logic        do_commit;
  logic        sel_bad;
  logic        frame_done;
  logic        slot_free;

  // Working frame update for a committed digit, plus frame-complete and slot-free decisions.
  always_comb begin
    dec         = seg_decode(st_seg[7:1]);
    nlow        = low_count(st_an);
    do_commit   = commit && (nlow == 4'd1);
    sel_bad     = commit && (nlow > 4'd1);
    idx         = 3'd0;
    w_digits_nx = w_digits;
    w_dp_nx     = w_dp;
    w_blank_nx  = w_blank;
    w_bad_nx    = w_bad;
    seen_nx     = seen;
    for (int i = 0; i < NDIG; i++) begin
      if (!st_an[i]) idx = 3'(i);
    end
    if (do_commit) begin
      w_digits_nx[{idx, 2'b00} +: 4] = dec.hit ? dec.nibble : 4'd0;
      w_blank_nx[idx] = dec.blank;
      w_bad_nx[idx]   = !dec.hit && !dec.blank;
      w_dp_nx[idx]    = ~st_seg[0];
      seen_nx[idx]    = 1'b1;
    end
    frame_done = do_commit && (seen_nx == 8'hFF);
    slot_free  = !frame_valid || frame_ready;
  end

  // Working registers, output slot, handshake and the two error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_digits    <= 32'd0;
      w_dp        <= 8'd0;
      w_blank     <= 8'd0;
      w_bad       <= 8'd0;
      seen        <= 8'd0;
      frame_valid <= 1'b0;
      digits      <= 32'd0;
      dp          <= 8'd0;
      blank       <= 8'd0;
      bad         <= 8'd0;
      sel_err     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      w_digits <= w_digits_nx;
      w_dp     <= w_dp_nx;
      w_blank  <= w_blank_nx;
      w_bad    <= w_bad_nx;
      sel_err  <= sel_bad;
      overrun  <= frame_done && !slot_free;
      seen     <= frame_done ? 8'd0 : seen_nx;
      if (frame_done && slot_free) begin
        frame_valid <= 1'b1;
        digits      <= w_digits_nx;
        dp          <= w_dp_nx;
        blank       <= w_blank_nx;
        bad         <= w_bad_nx;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

  localparam int STABLE = 4;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  an_n = 8'hFF;
  logic [7:0]  seg_in = 8'hFF;
  logic        frame_ready = 1'b0;
  logic        frame_valid;
  logic [31:0] digits;
  logic [7:0]  dp, blank, bad;
  logic        sel_err, overrun;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .NDIG(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .an_n        (an_n),
    .seg_in      (seg_in),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .digits      (digits),
    .dp          (dp),
    .blank       (blank),
    .bad         (bad),
    .sel_err     (sel_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // Reference model: run length of identical bus samples, and a frame of per-digit entries.
  logic [15:0] m_prev;
  int          m_run;
  logic        m_pend;
  logic [15:0] m_pend_x;
  logic [7:0]  m_seen;
  logic [3:0]  m_nib [8];
  logic [7:0]  m_dp, m_blank, m_bad;
  logic        m_valid;
  logic [31:0] m_o_dig;
  logic [7:0]  m_o_dp, m_o_blank, m_o_bad;
  logic        m_sel, m_ovr;

  int          n_valid, n_sel, n_ovr;
  logic [31:0] cap_dig;
  logic [7:0]  cap_dp, cap_blank, cap_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev  = 16'hFFFF;
    m_run   = 0;
    m_pend  = 1'b0;
    m_pend_x = 16'hFFFF;
    m_seen  = 8'h00;
    for (int i = 0; i < 8; i++) m_nib[i] = 4'h0;
    m_dp = 8'h00; m_blank = 8'h00; m_bad = 8'h00;
    m_valid = 1'b0;
    m_o_dig = 32'h0; m_o_dp = 8'h00; m_o_blank = 8'h00; m_o_bad = 8'h00;
    m_sel = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_edge();
    logic [15:0] x;
    int          lows, d, v;
    logic        full;
    m_sel = 1'b0;
    m_ovr = 1'b0;
    full  = 1'b0;
    if (m_pend) begin
      lows = 0;
      d    = 0;
      for (int i = 0; i < 8; i++) begin
        if (!m_pend_x[8+i]) begin
          lows++;
          d = i;
        end
      end
      if (lows > 1) begin
        m_sel = 1'b1;
      end else if (lows == 1) begin
        v = -1;
        for (int k = 0; k < 16; k++) if (m_pend_x[7:1] == HEX_TAB[k]) v = k;
        m_nib[d]   = (v >= 0) ? 4'(v) : 4'h0;
        m_blank[d] = (v < 0) && (m_pend_x[7:1] == 7'h7F);
        m_bad[d]   = (v < 0) && (m_pend_x[7:1] != 7'h7F);
        m_dp[d]    = !m_pend_x[0];
        m_seen[d]  = 1'b1;
        full = (m_seen == 8'hFF);
      end
    end
    if (full) begin
      if (!m_valid || frame_ready) begin
        m_valid = 1'b1;
        for (int i = 0; i < 8; i++) m_o_dig[4*i +: 4] = m_nib[i];
        m_o_dp = m_dp; m_o_blank = m_blank; m_o_bad = m_bad;
      end else begin
        m_ovr = 1'b1;
      end
      m_seen = 8'h00;
    end else if (m_valid && frame_ready) begin
      m_valid = 1'b0;
    end
    x = {an_n, seg_in};
    if (x != m_prev) m_run = 1;
    else if (m_run > 0 && m_run <= STABLE) m_run++;
    m_pend   = (m_run == STABLE);
    m_pend_x = x;
    m_prev   = x;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", {5'b0, frame_valid, digits, dp, blank, bad, sel_err, overrun},
                   {5'b0, m_valid, m_o_dig, m_o_dp, m_o_blank, m_o_bad, m_sel, m_ovr});
    if (frame_valid === 1'b1) begin
      n_valid++;
      cap_dig = digits; cap_dp = dp; cap_blank = blank; cap_bad = bad;
    end
    if (sel_err === 1'b1) n_sel++;
    if (overrun === 1'b1) n_ovr++;
  endtask

  task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int n);
    an_n   = an;
    seg_in = seg;
    repeat (n) tick();
  endtask

  function automatic logic [7:0] sel(input int d);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << d);
  endfunction

  function automatic logic [7:0] glyph(input int v, input logic dp_on);
    return {HEX_TAB[v], ~dp_on};
  endfunction

  task automatic do_reset();
    an_n = 8'hFF;
    seg_in = 8'hFF;
    rst = 1'b1;
    #1;
    model_reset();
    check("reset_async", {5'b0, frame_valid, digits, dp, blank, bad, sel_err, overrun}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {5'b0, frame_valid, digits, dp, blank, bad, sel_err, overrun}, 64'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] r_an, r_seg;
    int         r_v;

    model_reset();
    #2;
    do_reset();
    tick();

    // Basic scan of 0..7 with ready high.
    frame_ready = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 8; i++) hold(sel(i), glyph(i, 1'b0), 4);
    hold(8'hFF, 8'hFF, 6);
    check("scan_valid_pulses", 64'(n_valid), 64'd1);
    check("scan_digits", {32'h0, cap_dig}, {32'h0, 32'h76543210});
    check("scan_flags", {40'h0, cap_dp, cap_blank, cap_bad}, 64'h0);

    // Holds one cycle short of the window never commit.
    n_valid = 0;
    for (int i = 0; i < 8; i++) hold(sel(i), glyph(i + 8, 1'b0), 3);
    hold(8'hFF, 8'hFF, 3);
    check("short_hold_no_frame", 64'(n_valid), 64'd0);

    // Exact-window holds; last digit's commit lands on the fifth edge after it was applied.
    for (int i = 0; i < 7; i++) hold(sel(i), glyph(i + 8, 1'b0), 4);
    hold(sel(7), glyph(15, 1'b0), 4);
    check("latency_before", {63'h0, frame_valid}, 64'd0);
    hold(8'hFF, 8'hFF, 1);
    check("latency_at_t5", {63'h0, frame_valid}, 64'd1);
    check("latency_digits", {32'h0, digits}, {32'h0, 32'hFEDCBA98});
    hold(8'hFF, 8'hFF, 4);

    // Blank and undecodable digits.
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3)      hold(sel(i), 8'hFE, 4);
      else if (i == 5) hold(sel(i), 8'b1111_1101, 4);
      else             hold(sel(i), glyph(i, 1'b0), 4);
    end
    hold(8'hFF, 8'hFF, 4);
    check("blank_valid", 64'(n_valid), 64'd1);
    check("blank_digits", {32'h0, cap_dig}, {32'h0, 32'h76040210});
    check("blank_mask", {56'h0, cap_blank}, 64'h08);
    check("blank_dp", {56'h0, cap_dp}, 64'h08);
    check("bad_mask", {56'h0, cap_bad}, 64'h20);

    // Two selects low: one pulse when stable, none while glitching.
    n_sel = 0;
    hold(8'b1111_0011, glyph(1, 1'b0), 6);
    hold(8'hFF, 8'hFF, 4);
    check("sel_err_once", 64'(n_sel), 64'd1);
    n_sel = 0;
    for (int i = 0; i < 6; i++) begin
      hold(8'b1111_0011, glyph(2, 1'b0), 2);
      hold(8'b1110_0111, glyph(2, 1'b0), 2);
    end
    hold(8'hFF, 8'hFF, 3);
    check("sel_err_glitch", 64'(n_sel), 64'd0);

    // Back-pressure: second frame is dropped with an overrun pulse.
    frame_ready = 1'b0;
    n_ovr = 0;
    for (int i = 0; i < 8; i++) hold(sel(i), glyph(i + 8, 1'b0), 4);
    for (int i = 0; i < 8; i++) hold(sel(i), glyph(i, 1'b1), 4);
    hold(8'hFF, 8'hFF, 3);
    check("overrun_once", 64'(n_ovr), 64'd1);
    check("overrun_keeps_old", {31'h0, frame_valid, digits}, {31'h0, 1'b1, 32'hFEDCBA98});
    frame_ready = 1'b1;
    hold(8'hFF, 8'hFF, 1);
    check("transfer_drop", {63'h0, frame_valid}, 64'd0);

    // Reset mid-frame discards partial work.
    for (int i = 0; i < 5; i++) hold(sel(i), glyph(i + 1, 1'b0), 4);
    do_reset();
    n_valid = 0;
    for (int i = 0; i < 8; i++) hold(sel(i), glyph(15 - i, 1'b0), 4);
    hold(8'hFF, 8'hFF, 4);
    check("post_reset_valid", 64'(n_valid), 64'd1);
    check("post_reset_digits", {32'h0, cap_dig}, {32'h0, 32'h89ABCDEF});

    // Random bus traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r_v = int'($urandom_range(0, 19));
      if (r_v == 0)      r_an = 8'hFF;
      else if (r_v == 1) r_an = sel(int'($urandom_range(0, 7))) & sel(int'($urandom_range(0, 7)));
      else               r_an = sel(int'($urandom_range(0, 7)));
      r_v = int'($urandom_range(0, 9));
      if (r_v == 0)      r_seg = {7'h7F, 1'($urandom_range(0, 1))};
      else if (r_v == 1) r_seg = 8'($urandom);
      else               r_seg = glyph(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      frame_ready = ($urandom_range(0, 3) != 0);
      hold(r_an, r_seg, int'($urandom_range(1, 6)));
    end
    frame_ready = 1'b1;
    hold(8'hFF, 8'hFF, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receiver for a time-multiplexed 8-digit seven-segment display bus: the other end of the segment-driver path. It samples the scanned digit-select and segment lines and waits for each pattern to be stable. It decodes each pattern back to a hex nibble plus decimal point and assembles a full 8-digit frame. The frame goes out on a valid/ready handshake. Used as a display monitor for lab self-check and for loopback tests of display drivers.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples of (an_n, seg_in) required before a digit is committed; legal range 1..255.
NDIG, 8, number of digits; fixed at 8 in this revision.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
an_n  input  8  digit select, active-low one-hot; bit i selects digit i
seg_in  input  8  segment lines, active-low; [7]=a [6]=b [5]=c [4]=d [3]=e [2]=f [1]=g [0]=dp
frame_valid  output  1  held frame available
frame_ready  input  1  consumer accepts frame
digits  output  32  nibble i at [4i+3:4i]
dp  output  8  decimal point per digit, active-high
blank  output  8  digit i showed all segments off
bad  output  8  digit i showed a pattern that is not in the hex table
sel_err  output  1  one-cycle pulse: more than one an_n bit low in a stable window
overrun  output  1  one-cycle pulse: frame completed while previous frame unaccepted

Behaviour:
- Reset (async assert, sync release): all outputs 0; seen mask 0; counter 0; FSM IDLE; sample registers set to an_n=8'hFF and seg_in=8'hFF.
- Inputs are registered once (s_an, s_seg). A change is detected by comparing the new sample against the previous sample.
- FSM IDLE: any change -> COUNT, with counter=1.
- FSM COUNT: a change restarts counter=1. Otherwise the counter increments. When the counter reaches STABLE_CYCLES, the pair is evaluated -> HELD.
- FSM HELD: no recommit while the pair is unchanged. A change -> COUNT, with counter=1.
- Evaluation rules:
  - s_an==8'hFF: idle bus, no action.
  - Exactly one bit low: commit that digit.
  - Two or more bits low: pulse sel_err, no commit.
- Commit of digit i:
  - Look up s_seg[7:1] in the hex table: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Hit: nibble=index, blank_i=0, bad_i=0.
  - 1111111: nibble=0, blank_i=1, bad_i=0.
  - Anything else: nibble=0, bad_i=1.
  - dp_i = ~s_seg[0]. Set seen[i].
  - A recommit of the same digit within a frame overwrites its working entry.
- Latency: an input pair applied at edge t and then held is committed at edge t+1+STABLE_CYCLES.
- Frame completion: on the commit that makes seen==8'hFF:
  - If the output slot is free, or is being accepted in the same cycle: copy the working registers (including that commit) to the outputs; frame_valid=1 on the next edge.
  - Otherwise: pulse overrun, drop the new frame, keep the old outputs unchanged.
  - In both cases clear seen.
- Handshake: a transfer occurs when frame_valid && frame_ready.
  - frame_valid falls on the next edge unless a new frame loads in the same cycle, in which case it stays 1 with the new data.
  - Output data is stable while frame_valid=1 and frame_ready=0.
- A reset mid-frame discards the partial frame and the held frame.

Decomposition:
- Package seg_pkg:
  - Hex-to-segment table constant, 16 x 7 bits, shared with the segment driver.
  - SEG_BLANK = 7'h7F.
  - Digit-state FSM enum {IDLE, COUNT, HELD}.
  - Function seg_decode(7-bit) returning {hit, blank, nibble}.
- One sub-module: seg_stable_filter. It holds the sample registers, counter and FSM, and outputs a one-cycle commit strobe with the stable an_n/seg_in.
- The top level does the decode, the working and output registers, and the handshake.

Test Plan:
- Scan digits 0..7 with patterns for 0..7 (each held 4 cycles, frame_ready=1) -> frame_valid pulses once; digits=32'h76543210; dp=0; blank=0; bad=0.
- Hold each digit for only 3 cycles (STABLE_CYCLES=4) -> no commit, frame_valid stays 0; extend to 4 cycles -> commit at edge t+5.
- Digit 3 pattern 1111111 with dp low; digit 5 pattern 1111110 -> blank=8'h08, dp=8'h08, bad=8'h20, nibbles 3 and 5 equal 0.
- an_n=8'b11110011 held stable -> sel_err pulses exactly once, seen unchanged; glitchy toggling -> no pulse.
- frame_ready=0 with two full frames scanned -> first frame held, overrun pulses once at second completion; frame_ready=1 -> transfer, frame_valid drops next cycle.
- Assert rst after 5 digits committed, then scan 8 digits -> outputs 0 during reset; the first frame_valid after reset carries only post-reset data.
